// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one tagged memory port among N_CH device channels.
//            Round-robin selection among eligible channels. The selection
//            is locked until memory accepts the request. An owner table
//            indexed by tag routes each memory answer back to the channel
//            that issued it.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            ch_qry_cmd/blk/idx   - per-channel request (cmd 0=NONE,1=LOAD,2=STORE)
//            ch_ack               - per-channel acceptance tag (nonzero = accepted)
//            ch_ans_blk/ch_ans_tag- per-channel answer (tag nonzero = valid)
//            mem_qry_cmd/blk/idx  - query presented to memory
//            mem_ack              - memory acceptance tag
//            mem_ans_blk/tag      - memory answer
//            err_tag              - sticky: answer for a tag with no owner
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int N_CH    = 2,
  parameter int BLK_W   = 64,
  parameter int IDX_W   = 29,
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CH-1:0][1:0]        ch_qry_cmd,
  input  logic [N_CH-1:0][BLK_W-1:0]  ch_qry_blk,
  input  logic [N_CH-1:0][IDX_W-1:0]  ch_qry_idx,
  output logic [N_CH-1:0][TAG_W-1:0]  ch_ack,
  output logic [N_CH-1:0][BLK_W-1:0]  ch_ans_blk,
  output logic [N_CH-1:0][TAG_W-1:0]  ch_ans_tag,
  output logic [1:0]                  mem_qry_cmd,
  output logic [BLK_W-1:0]            mem_qry_blk,
  output logic [IDX_W-1:0]            mem_qry_idx,
  input  logic [TAG_W-1:0]            mem_ack,
  input  logic [BLK_W-1:0]            mem_ans_blk,
  input  logic [TAG_W-1:0]            mem_ans_tag,
  output logic                        err_tag
);

  localparam int c_ch_w   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int c_n_tags = 2 ** TAG_W;
  localparam int c_cnt_w  = $clog2(MAX_OUT + 1);
  localparam logic [c_cnt_w-1:0] c_max_out = c_cnt_w'(MAX_OUT);
  localparam logic [c_ch_w-1:0]  c_last_ch = c_ch_w'(N_CH - 1);

  localparam logic [0:0] c_st_idle   = 1'b0;
  localparam logic [0:0] c_st_locked = 1'b1;

  logic [0:0]          r_state;
  logic [c_ch_w-1:0]   r_grant;
  logic [c_ch_w-1:0]   r_rr_ptr;
  logic [c_n_tags-1:0] r_valid;
  logic [c_ch_w-1:0]   r_owner [c_n_tags];
  logic [c_cnt_w-1:0]  r_cnt   [N_CH];
  logic                r_err;

  logic [N_CH-1:0]     w_elig;
  logic                w_win_found;
  logic [c_ch_w-1:0]   w_win;
  logic [c_ch_w-1:0]   w_cand;
  logic                w_q_valid;
  logic [c_ch_w-1:0]   w_owner;
  logic                w_acc;
  logic                w_hit;
  logic [c_ch_w-1:0]   w_ans_owner;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_elig
    assign w_elig[gi] = (ch_qry_cmd[gi] != 2'd0) && (r_cnt[gi] < c_max_out);
  end

  // Scan from the highest offset down so the channel closest to r_rr_ptr
  // is the last assignment and wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win       = '0;
    w_cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_cand = c_ch_w'((int'(r_rr_ptr) + k) % N_CH);
      if (w_elig[w_cand]) begin
        w_win_found = 1'b1;
        w_win       = w_cand;
      end
    end
  end

  // In LOCKED, a granted channel that dropped its command leaves no query
  // on the port. Any mem_ack in that cycle is then ignored.
  assign w_q_valid = (r_state == c_st_idle) ? w_win_found
                                            : (ch_qry_cmd[r_grant] != 2'd0);
  assign w_owner   = (r_state == c_st_idle) ? w_win : r_grant;
  assign w_acc     = rst_n && w_q_valid && (mem_ack != '0);
  assign w_hit     = rst_n && (mem_ans_tag != '0) && r_valid[mem_ans_tag];
  assign w_ans_owner = r_owner[mem_ans_tag];

  assign mem_qry_cmd = (rst_n && w_q_valid) ? ch_qry_cmd[w_owner] : 2'd0;
  assign mem_qry_blk = (rst_n && w_q_valid) ? ch_qry_blk[w_owner] : '0;
  assign mem_qry_idx = (rst_n && w_q_valid) ? ch_qry_idx[w_owner] : '0;
  assign err_tag     = r_err;

  always_comb begin
    ch_ack     = '0;
    ch_ans_tag = '0;
    ch_ans_blk = '0;
    if (w_acc) begin
      ch_ack[w_owner] = mem_ack;
    end
    if (w_hit) begin
      ch_ans_tag[w_ans_owner] = mem_ans_tag;
      ch_ans_blk[w_ans_owner] = mem_ans_blk;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_valid  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_win_found && (mem_ack == '0)) begin
            r_state <= c_st_locked;
            r_grant <= w_win;
          end
        end
        default: begin
          if (w_acc || (ch_qry_cmd[r_grant] == 2'd0)) begin
            r_state <= c_st_idle;
          end
        end
      endcase

      if (w_acc) begin
        r_rr_ptr <= (w_owner == c_last_ch) ? '0 : w_owner + c_ch_w'(1);
      end

      // Answer clears first so an ack reusing the same tag this cycle
      // leaves the entry valid.
      if (w_hit) begin
        r_valid[mem_ans_tag] <= 1'b0;
      end
      if (w_acc) begin
        r_valid[mem_ack] <= 1'b1;
      end

      if ((mem_ans_tag != '0) && !r_valid[mem_ans_tag]) begin
        r_err <= 1'b1;
      end
    end
  end

  // Owner entries are only meaningful while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_owner[mem_ack] <= w_owner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_acc && (w_owner == c_ch_w'(i)) &&
            !(w_hit && (w_ans_owner == c_ch_w'(i)))) begin
          if (r_cnt[i] < c_max_out) begin
            r_cnt[i] <= r_cnt[i] + c_cnt_w'(1);
          end
        end else if (w_hit && (w_ans_owner == c_ch_w'(i)) &&
                     !(w_acc && (w_owner == c_ch_w'(i)))) begin
          if (r_cnt[i] != '0) begin
            r_cnt[i] <= r_cnt[i] - c_cnt_w'(1);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter (N_CH=2, MAX_OUT=2).
//            The bench plays the memory. Expected channel acks and answers
//            go into queues and are matched against the channel outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int NC = 2;
  localparam int BW = 64;
  localparam int IW = 29;
  localparam int TW = 4;

  logic                   clk;
  logic                   rst_n;
  logic [NC-1:0][1:0]     ch_qry_cmd;
  logic [NC-1:0][BW-1:0]  ch_qry_blk;
  logic [NC-1:0][IW-1:0]  ch_qry_idx;
  logic [NC-1:0][TW-1:0]  ch_ack;
  logic [NC-1:0][BW-1:0]  ch_ans_blk;
  logic [NC-1:0][TW-1:0]  ch_ans_tag;
  logic [1:0]             mem_qry_cmd;
  logic [BW-1:0]          mem_qry_blk;
  logic [IW-1:0]          mem_qry_idx;
  logic [TW-1:0]          mem_ack;
  logic [BW-1:0]          mem_ans_blk;
  logic [TW-1:0]          mem_ans_tag;
  logic                   err_tag;

  typedef struct {
    int          ch;
    int          tag;
    logic [63:0] blk;
  } exp_t;

  exp_t q_ack[$];
  exp_t q_ans[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_arbiter #(.N_CH(NC), .BLK_W(BW), .IDX_W(IW), .TAG_W(TW), .MAX_OUT(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ch_qry_cmd(ch_qry_cmd), .ch_qry_blk(ch_qry_blk), .ch_qry_idx(ch_qry_idx),
    .ch_ack(ch_ack), .ch_ans_blk(ch_ans_blk), .ch_ans_tag(ch_ans_tag),
    .mem_qry_cmd(mem_qry_cmd), .mem_qry_blk(mem_qry_blk), .mem_qry_idx(mem_qry_idx),
    .mem_ack(mem_ack), .mem_ans_blk(mem_ans_blk), .mem_ans_tag(mem_ans_tag),
    .err_tag(err_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_ack(input int ch, input int tag);
    exp_t e;
    e.ch = ch; e.tag = tag; e.blk = '0;
    q_ack.push_back(e);
  endtask

  task automatic push_ans(input int ch, input int tag, input logic [63:0] blk);
    exp_t e;
    e.ch = ch; e.tag = tag; e.blk = blk;
    q_ans.push_back(e);
  endtask

  // Match every nonzero channel ack/answer against the queue fronts. Any
  // expectation left over for this cycle was never produced.
  task automatic monitor();
    exp_t e;
    for (int c = 0; c < NC; c++) begin
      if (ch_ack[c] != '0) begin
        if (q_ack.size() == 0) check("ack_unexpected", 64'(ch_ack[c]), 64'd0);
        else begin
          e = q_ack.pop_front();
          check("ack_ch", 64'(c), 64'(e.ch));
          check("ack_tag", 64'(ch_ack[c]), 64'(e.tag));
        end
      end
      if (ch_ans_tag[c] != '0) begin
        if (q_ans.size() == 0) check("ans_unexpected", 64'(ch_ans_tag[c]), 64'd0);
        else begin
          e = q_ans.pop_front();
          check("ans_ch", 64'(c), 64'(e.ch));
          check("ans_tag", 64'(ch_ans_tag[c]), 64'(e.tag));
          check("ans_blk", ch_ans_blk[c], e.blk);
        end
      end else begin
        check("ans_blk_idle", ch_ans_blk[c], 64'd0);
      end
    end
    if (q_ack.size() != 0) begin
      check("ack_missing", 64'(q_ack.size()), 64'd0);
      q_ack.delete();
    end
    if (q_ans.size() != 0) begin
      check("ans_missing", 64'(q_ans.size()), 64'd0);
      q_ans.delete();
    end
  endtask

  // Inputs are set at posedge+1; outputs are sampled at the falling edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ch_qry_cmd  = '0;
    ch_qry_blk  = '0;
    ch_qry_idx  = '0;
    mem_ack     = '0;
    mem_ans_blk = '0;
    mem_ans_tag = '0;
  endtask

  task automatic set_req(input int ch, input logic [1:0] cmd, input logic [28:0] idx);
    ch_qry_cmd[ch] = cmd;
    ch_qry_idx[ch] = idx;
    ch_qry_blk[ch] = {35'd0, idx} ^ 64'hDEAD_0000_0000_0000;
  endtask

  // Busy inputs while reset is low: the outputs must still stay quiet.
  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 2'd1, 29'h55);
    mem_ack     = 4'd5;
    mem_ans_tag = 4'd3;
    mem_ans_blk = 64'h1234;
    #2;
    check("rst_qry_cmd", 64'(mem_qry_cmd), 64'd0);
    check("rst_qry_idx", 64'(mem_qry_idx), 64'd0);
    check("rst_qry_blk", mem_qry_blk, 64'd0);
    check("rst_ch_ack", 64'(ch_ack), 64'd0);
    check("rst_ans_tag", 64'(ch_ans_tag), 64'd0);
    check("rst_ans_blk0", ch_ans_blk[0], 64'd0);
    check("rst_err", 64'(err_tag), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    clear_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    do_reset();

    // Single request accepted in the same cycle, then answered.
    set_req(0, 2'd1, 29'h10);
    mem_ack = 4'd3;
    push_ack(0, 3);
    #1;
    check("single_qry_idx", 64'(mem_qry_idx), 64'h10);
    check("single_qry_cmd", 64'(mem_qry_cmd), 64'd1);
    tick();
    clear_inputs();
    tick();
    mem_ans_tag = 4'd3;
    mem_ans_blk = 64'hAA;
    push_ans(0, 3, 64'hAA);
    tick();
    clear_inputs();
    check("single_err", 64'(err_tag), 64'd0);

    // Round-robin with both channels requesting and an ack every cycle.
    do_reset();
    set_req(0, 2'd1, 29'h100);
    set_req(1, 2'd2, 29'h200);
    for (int t = 1; t <= 4; t++) begin
      mem_ack = 4'(t);
      push_ack((t - 1) % 2, t);
      #1;
      check("rr_qry_idx", 64'(mem_qry_idx), (t % 2 == 1) ? 64'h100 : 64'h200);
      tick();
    end
    clear_inputs();
    for (int t = 1; t <= 4; t++) begin
      mem_ans_tag = 4'(t);
      mem_ans_blk = 64'hB000 + 64'(t);
      push_ans((t - 1) % 2, t, 64'hB000 + 64'(t));
      tick();
    end
    clear_inputs();

    // Lock: ch0 wins and holds the port through three unacked cycles.
    do_reset();
    set_req(0, 2'd1, 29'h0A0);
    set_req(1, 2'd1, 29'h0B0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("lock_qry_idx", 64'(mem_qry_idx), 64'h0A0);
      tick();
    end
    mem_ack = 4'd5;
    push_ack(0, 5);
    #1;
    check("lock_ack_idx", 64'(mem_qry_idx), 64'h0A0);
    tick();
    ch_qry_cmd[0] = 2'd0;
    mem_ack = 4'd6;
    push_ack(1, 6);
    #1;
    check("lock_next_idx", 64'(mem_qry_idx), 64'h0B0);
    tick();
    clear_inputs();

    // Throttle: ch0 at its outstanding limit is skipped until answered.
    do_reset();
    set_req(0, 2'd1, 29'h300);
    mem_ack = 4'd1;
    push_ack(0, 1);
    tick();
    mem_ack = 4'd2;
    push_ack(0, 2);
    tick();
    mem_ack = 4'd0;
    set_req(1, 2'd1, 29'h400);
    #1;
    check("thr_ch1_idx", 64'(mem_qry_idx), 64'h400);
    tick();
    mem_ack = 4'd3;
    push_ack(1, 3);
    tick();
    ch_qry_cmd[1] = 2'd0;
    mem_ack = 4'd0;
    #1;
    check("thr_blocked", 64'(mem_qry_cmd), 64'd0);
    tick();
    mem_ans_tag = 4'd1;
    mem_ans_blk = 64'hC1;
    push_ans(0, 1, 64'hC1);
    #1;
    check("thr_still_blocked", 64'(mem_qry_cmd), 64'd0);
    tick();
    mem_ans_tag = 4'd0;
    mem_ack = 4'd4;
    push_ack(0, 4);
    #1;
    check("thr_regrant", 64'(mem_qry_idx), 64'h300);
    tick();
    clear_inputs();

    // Stray answer for a tag that was never acked.
    do_reset();
    mem_ans_tag = 4'd7;
    mem_ans_blk = 64'hEE;
    tick();
    clear_inputs();
    for (int c = 0; c < 3; c++) begin
      check("stray_err", 64'(err_tag), 64'd1);
      tick();
    end

    // Same-cycle answer and ack on one tag: old owner gets the answer.
    do_reset();
    set_req(0, 2'd1, 29'h500);
    mem_ack = 4'd1;
    push_ack(0, 1);
    tick();
    ch_qry_cmd[0] = 2'd0;
    set_req(1, 2'd2, 29'h600);
    mem_ack = 4'd1;
    mem_ans_tag = 4'd1;
    mem_ans_blk = 64'h55;
    push_ack(1, 1);
    push_ans(0, 1, 64'h55);
    tick();
    clear_inputs();
    mem_ans_tag = 4'd1;
    mem_ans_blk = 64'h66;
    push_ans(1, 1, 64'h66);
    tick();
    clear_inputs();
    check("reuse_err", 64'(err_tag), 64'd0);

    // Reset mid-flight discards outstanding tags and counts.
    do_reset();
    set_req(0, 2'd1, 29'h700);
    set_req(1, 2'd1, 29'h800);
    for (int t = 1; t <= 3; t++) begin
      mem_ack = 4'(t);
      push_ack((t - 1) % 2, t);
      tick();
    end
    clear_inputs();
    do_reset();
    mem_ans_tag = 4'd1;
    mem_ans_blk = 64'h77;
    tick();
    clear_inputs();
    check("late_ans_err", 64'(err_tag), 64'd1);
    set_req(0, 2'd1, 29'h900);
    mem_ack = 4'd1;
    push_ack(0, 1);
    tick();
    mem_ack = 4'd2;
    push_ack(0, 2);
    #1;
    check("post_rst_cmd", 64'(mem_qry_cmd), 64'd1);
    tick();
    clear_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter N_CH, default 2, number of device channels sharing one memory port (2..8).
REQ-002 Parameter BLK_W, default 64, memory block width in bits.
REQ-003 Parameter IDX_W, default 29, block index width.
REQ-004 Parameter TAG_W, default 4, tag width; tag 0 means "no tag", so DEPTH = 2^TAG_W - 1 usable tags.
REQ-005 Parameter MAX_OUT, default 8, maximum outstanding requests per channel (1..DEPTH).
REQ-006 The block SHALL use one clock and an asynchronous, active-low reset, with the ports below.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 ch_qry_cmd  in  N_CH x 2  per-channel command; 0 = NONE, 1 = LOAD, 2 = STORE.
REQ-010 ch_qry_blk  in  N_CH x BLK_W  per-channel store data.
REQ-011 ch_qry_idx  in  N_CH x IDX_W  per-channel block index.
REQ-012 ch_ack  out  N_CH x TAG_W  per-channel acceptance tag; nonzero for one cycle = request accepted.
REQ-013 ch_ans_blk  out  N_CH x BLK_W  per-channel answer data.
REQ-014 ch_ans_tag  out  N_CH x TAG_W  per-channel answer tag; nonzero for one cycle = answer valid.
REQ-015 mem_qry_cmd / mem_qry_blk / mem_qry_idx  out  2 / BLK_W / IDX_W  query to memory.
REQ-016 mem_ack  in  TAG_W  memory acceptance tag.
REQ-017 mem_ans_blk / mem_ans_tag  in  BLK_W / TAG_W  memory answer.
REQ-018 err_tag  out  1  sticky: answer received for a tag with no recorded owner.

Function
REQ-019 A channel is a requester while ch_qry_cmd != NONE; it holds cmd/blk/idx stable until its ch_ack is nonzero.
REQ-020 A channel is eligible when it is a requester and its outstanding count < MAX_OUT.
REQ-021 FSM states: IDLE, LOCKED; reset state IDLE.
REQ-022 IDLE: winner = first eligible channel at or after rr_ptr (wrapping N_CH-1 -> 0); no eligible channel -> mem_qry_cmd = NONE.
REQ-023 The winner's cmd/blk/idx SHALL drive mem_qry_* combinationally in the same cycle (zero added latency).
REQ-024 IDLE, winner present, mem_ack == 0: next state LOCKED, grant register = winner.
REQ-025 LOCKED: mem_qry_* driven by granted channel regardless of other requesters; stay until mem_ack != 0.
REQ-026 On mem_ack != 0 (either state): ch_ack[owner] = mem_ack same cycle, all other ch_ack = 0; owner_tbl[mem_ack] = owner, valid[mem_ack] = 1; owner count +1; rr_ptr = owner+1 mod N_CH; next state IDLE.
REQ-027 mem_ack != 0 while no query is driven SHALL be ignored.
REQ-028 On mem_ans_tag != 0 with valid set: ch_ans_tag[owner_tbl[tag]] = mem_ans_tag, ch_ans_blk[owner] = mem_ans_blk, same cycle; valid cleared; owner count -1.
REQ-029 mem_ans_tag != 0 with valid clear: no channel answer; err_tag set until reset.
REQ-030 ch_ans_blk of non-addressed channels SHALL be 0.
REQ-031 Same-cycle answer and ack on same tag: answer routed using old owner, then entry rewritten by the new ack (valid stays 1).
REQ-032 Same-cycle answer and ack on same channel: count unchanged.
REQ-033 Counts saturate: never exceed MAX_OUT, never below 0.
REQ-034 A channel dropping cmd to NONE in LOCKED before ack is a protocol violation; the block SHALL return to IDLE next cycle without table update.

Reset
REQ-035 While rst_n = 0: state IDLE, rr_ptr = 0, all valid = 0, all counts = 0, err_tag = 0, mem_qry_cmd = NONE, mem_qry_blk/idx = 0, all ch_ack/ch_ans_tag/ch_ans_blk = 0.
REQ-036 Reset asserted mid-transaction SHALL discard all outstanding tags; late answers after reset set err_tag.

Verification
REQ-037 Single request: ch0 LOAD idx 0x10, mem_ack = 3 same cycle -> ch_ack[0] = 3; later mem_ans_tag = 3, blk 0xAA -> ch_ans_tag[0] = 3, ch_ans_blk[0] = 0xAA, ch1 outputs 0.
REQ-038 Round-robin: ch0 and ch1 both request continuously, memory acks every cycle with tags 1,2,3,4 -> owners ch0,ch1,ch0,ch1.
REQ-039 Lock: ch0 wins, mem_ack = 0 for 3 cycles while ch1 requests -> mem_qry_idx stays ch0's index; ack on cycle 4 goes to ch0 only.
REQ-040 Throttle: MAX_OUT = 2, ch0 gets tags 1,2 unanswered -> ch0 not granted; ch1 granted; after answer tag 1, ch0 granted again.
REQ-041 Stray answer: mem_ans_tag = 7 never acked -> no ch_ans_tag nonzero, err_tag = 1 until rst_n low.
REQ-042 Reset mid-flight: 3 tags outstanding, pulse rst_n low -> counts 0, valid 0; answer tag 1 afterwards -> err_tag = 1.
